datamemory_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port `datamemory` block. It lets two requesters share the memory, for example the CPU load/store stage on port 0 and a debug/DMA loader on port 1. Each port has a valid/ready request channel and a one-cycle response pulse. The block serialises accesses, drives the memory's `address`/`dataIn`/`we`, captures `dataOut`, and uses round-robin priority when both ports request in the same cycle.

---
 rtl/datamemory_arbiter.sv | 178 +++++++++++++++++
 tb/tb_datamemory_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamemory_arbiter.sv
// datamemory_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-port
// data memory. Each access runs IDLE -> ACCESS -> RESP and finishes with
// a one-cycle completion pulse on the port that issued it.
module datamemory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  // port 0 request / response
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  // port 1 request / response
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dataOut,
  // status
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Arbitration history: the port granted most recently. Starts at 1 so
  // port 0 wins the very first tie.
  logic last_grant_reg, last_grant_next;

  // Request captured at the handshake; drives the memory until the next one.
  logic                  lat_we_reg;
  logic                  lat_port_reg;
  logic [ADDR_WIDTH-1:0] lat_addr_reg;
  logic [DATA_WIDTH-1:0] lat_wdata_reg;

  // Ports gathered into arrays so both sides can be indexed by port id.
  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [1:0]            req_ready;

  logic                  rsp_valid_reg [2];
  logic [DATA_WIDTH-1:0] rsp_rdata_reg [2];
  logic [1:0]            rsp_hit;

  logic winner;
  logic any_req;
  logic handshake;

  assign req_valid    = {req1_valid, req0_valid};
  assign req_we       = {req1_we, req0_we};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp0_rdata = rsp_rdata_reg[0];
  assign rsp1_rdata = rsp_rdata_reg[1];

  // The memory address/data simply follow the last captured request; they
  // are only meaningful while mem_we or the read sample is in effect.
  assign mem_address = lat_addr_reg;
  assign mem_dataIn  = lat_wdata_reg;

  // Winner selection: a lone requester wins; a tie goes to the port that was
  // not granted last, which alternates grants under continuous contention.
  always_comb begin
    any_req = |req_valid;
    if (req_valid == 2'b11) begin
      winner = ~last_grant_reg;
    end else begin
      winner = req_valid[1];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a handshake launches a fixed two-cycle access.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (handshake) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready to the winner in IDLE, write strobe in ACCESS,
  // response steering in RESP. Reset blocks both ready and the strobe.
  always_comb begin
    req_ready = 2'b00;
    rsp_hit   = 2'b00;
    mem_we    = 1'b0;
    busy      = (state_reg != IDLE);
    if (state_reg == IDLE && !rst && any_req) begin
      req_ready[winner] = 1'b1;
    end
    if (state_reg == ACCESS) begin
      mem_we = lat_we_reg & ~rst;
    end
    if (state_reg == RESP) begin
      rsp_hit[lat_port_reg] = 1'b1;
    end
  end

  assign handshake       = |req_ready;
  assign last_grant_next = handshake ? winner : last_grant_reg;

  // Capture the winning request and update arbitration history on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      lat_we_reg     <= 1'b0;
      lat_port_reg   <= 1'b0;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      if (handshake) begin
        lat_we_reg    <= req_we[winner];
        lat_port_reg  <= winner;
        lat_addr_reg  <= req_addr[winner];
        lat_wdata_reg <= req_wdata[winner];
      end
    end
  end

  // Per-port completion: pulse valid for one cycle when leaving RESP; read
  // data is taken from the memory, a write leaves the previous rdata intact.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_rdata_reg[gi] <= '0;
        end else begin
          rsp_valid_reg[gi] <= rsp_hit[gi];
          if (rsp_hit[gi] && !lat_we_reg) begin
            rsp_rdata_reg[gi] <= mem_dataOut;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Bench for datamemory_arbiter: a behavioural memory, a driver that feeds
// per-port request queues, and a monitor that scores every response against
// expectations pushed at handshake time.
module tb_datamemory_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [9:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [9:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_rdata;
  logic [9:0]  mem_address;
  logic [31:0] mem_dataIn, mem_dataOut;
  logic        mem_we, busy;

  datamemory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_we(mem_we),
    .mem_dataOut(mem_dataOut), .busy(busy)
  );

  typedef struct { bit we; logic [9:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { int port; logic [31:0] data; int cyc; } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_count = 0;
  bit tb_init;

  logic [31:0] dmem    [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_last [2];

  req_t pq0[$];
  req_t pq1[$];
  exp_t sb[$];
  int   grant_log[$];
  int   hs_log[$];

  // Model of the in-flight access, in cycle numbers.
  logic [9:0]  acc_addr;
  logic [31:0] acc_wdata;
  bit          acc_we;
  int          acc_cyc;
  int          busy_end;
  bit          model_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory: write commits at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= '0;
      dmem[1] <= 32'h11;
      dmem[2] <= 32'h22;
    end else if (mem_we) begin
      dmem[mem_address] <= mem_dataIn;
    end
    mem_dataOut <= dmem[mem_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    acc_addr   = '0;
    acc_wdata  = '0;
    acc_we     = 1'b0;
    acc_cyc    = -100;
    busy_end   = -100;
    model_last = 1'b1;
    ref_last[0] = '0;
    ref_last[1] = '0;
  endtask

  // Called just after the negedge that precedes the handshake edge.
  task automatic note_hs(input int p, input bit we, input logic [9:0] a,
                         input logic [31:0] d, input bit push);
    exp_t e;
    acc_addr   = a;
    acc_wdata  = d;
    acc_we     = we;
    acc_cyc    = cyc + 1;
    busy_end   = cyc + 2;
    model_last = p[0];
    grant_log.push_back(p);
    hs_log.push_back(cyc);
    if (push) begin
      if (we) begin
        ref_mem[a] = d;
        e.data = ref_last[p];
      end else begin
        e.data = ref_mem[a];
        ref_last[p] = e.data;
      end
      e.port = p;
      e.cyc  = cyc + 3;
      sb.push_back(e);
    end
  endtask

  // Drive both request queues until drained, checking ready against the
  // arbitration rules each cycle.
  task automatic run_queues(input bit gaps, input int budget);
    int n;
    bit hs0, hs1, w, e0, e1, idle_exp;
    n = 0; hs0 = 0; hs1 = 0;
    while (pq0.size() > 0 || pq1.size() > 0) begin
      @(negedge clk);
      if (hs0) req0_valid = 1'b0;
      if (hs1) req1_valid = 1'b0;
      if (!req0_valid && pq0.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        req0_valid = 1'b1; req0_we = pq0[0].we; req0_addr = pq0[0].addr; req0_wdata = pq0[0].wdata;
      end
      if (!req1_valid && pq1.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        req1_valid = 1'b1; req1_we = pq1[0].we; req1_addr = pq1[0].addr; req1_wdata = pq1[0].wdata;
      end
      #1;
      idle_exp = !(cyc >= acc_cyc && cyc <= busy_end);
      w  = (req0_valid && req1_valid) ? !model_last : req1_valid;
      e0 = idle_exp && !rst && (req0_valid || req1_valid) && !w;
      e1 = idle_exp && !rst && (req0_valid || req1_valid) && w;
      if (req0_valid || req1_valid) begin
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
      end
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0) begin note_hs(0, pq0[0].we, pq0[0].addr, pq0[0].wdata, 1'b1); void'(pq0.pop_front()); end
      if (hs1) begin note_hs(1, pq1[0].we, pq1[0].addr, pq1[0].wdata, 1'b1); void'(pq1.pop_front()); end
      n++;
      if (n > budget) begin
        total++; bad++;
        $display("FAIL timeout: %0d requests still queued after %0d cycles", pq0.size() + pq1.size(), budget);
        pq0.delete(); pq1.delete();
      end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: strobe, busy, memory bus and response scoreboard.
  exp_t        m_e;
  int          m_port;
  logic [31:0] m_data;
  always @(negedge clk) begin
    #2;
    if (mem_we) we_count++;
    check("busy", 32'(busy), 32'((cyc >= acc_cyc) && (cyc <= busy_end)));
    if (mem_we || ((cyc == acc_cyc) && acc_we && !rst))
      check("mem_we", 32'(mem_we), 32'((cyc == acc_cyc) && acc_we && !rst));
    if (cyc == acc_cyc) begin
      check("mem_address", 32'(mem_address), 32'(acc_addr));
      check("mem_dataIn", mem_dataIn, acc_wdata);
    end
    if (req0_ready || req1_ready)
      check("ready_only_idle", {29'd0, busy, rst, req0_ready & req1_ready}, 32'd0);
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missing_rsp: port %0d got none expected pulse at cyc %0d", sb[0].port, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rsp0=%0d rsp1=%0d expected none (cyc %0d)", rsp0_valid, rsp1_valid, cyc);
      end else begin
        m_e    = sb.pop_front();
        m_port = rsp1_valid ? 1 : 0;
        m_data = rsp1_valid ? rsp1_rdata : rsp0_rdata;
        check("rsp_port", 32'(m_port), 32'(m_e.port));
        check("rsp_rdata", m_data, m_e.data);
        check("rsp_cycle", 32'(cyc), 32'(m_e.cyc));
        check("rsp_both", 32'(rsp0_valid & rsp1_valid), 32'd0);
        $display("txn port=%0d rdata=%08h cyc=%0d", m_port, m_data, cyc);
      end
    end
  end

  int we_before;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    ref_mem[1] = 32'h11;
    ref_mem[2] = 32'h22;
    model_reset();
    tb_init = 1'b1;
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd9; req0_wdata = $urandom;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'd4; req1_wdata = $urandom;

    // Reset values, with both requesters asserting valid.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tb_init = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_mem_dataIn", mem_dataIn, 32'd0);
      check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
      check("rst_rsp1_rdata", rsp1_rdata, 32'd0);
      check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: both ports hold reads; grants must alternate 3 cycles apart.
    grant_log.delete(); hs_log.delete();
    for (int k = 0; k < 3; k++) begin
      pq0.push_back('{1'b0, 10'd1, $urandom});
      pq1.push_back('{1'b0, 10'd2, $urandom});
    end
    run_queues(1'b0, 100);
    check("fair_count", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < grant_log.size(); k++) begin
      check("fair_grant", 32'(grant_log[k]), 32'(k % 2));
      if (k > 0) check("fair_spacing", 32'(hs_log[k] - hs_log[k-1]), 32'd3);
    end

    // Port 0 write then read back.
    we_before = we_count;
    pq0.push_back('{1'b1, 10'd5, 32'h000000A5});
    pq0.push_back('{1'b0, 10'd5, $urandom});
    run_queues(1'b0, 100);
    check("wr_rd_we_cycles", 32'(we_count - we_before), 32'd1);

    // Write aborted by reset during ACCESS: no strobe, no response.
    we_before = we_count;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd7; req0_wdata = 32'hDEADBEEF;
    #1;
    check("abort_ready", 32'(req0_ready), 32'd1);
    note_hs(0, 1'b1, 10'd7, 32'hDEADBEEF, 1'b0);
    busy_end = acc_cyc;
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("abort_we_cycles", 32'(we_count - we_before), 32'd0);
    pq0.push_back('{1'b0, 10'd7, $urandom});
    run_queues(1'b0, 100);

    // Tie with last grant on port 0: port 1 write first, then port 0 read.
    grant_log.delete(); hs_log.delete();
    pq1.push_back('{1'b1, 10'd3, 32'h12345678});
    pq0.push_back('{1'b0, 10'd3, $urandom});
    run_queues(1'b0, 100);
    check("tie_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("tie_first", 32'(grant_log[0]), 32'd1);
      check("tie_second", 32'(grant_log[1]), 32'd0);
    end

    // Port 1 back-to-back writes then reads.
    for (int k = 0; k < 10; k++) pq1.push_back('{1'b1, 10'(k), 32'(k)});
    for (int k = 0; k < 10; k++) pq1.push_back('{1'b0, 10'(k), $urandom});
    run_queues(1'b0, 200);

    // Random traffic on both ports over a small address window.
    for (int k = 0; k < 30; k++) begin
      pq0.push_back('{1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom});
      pq1.push_back('{1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom});
    end
    run_queues(1'b1, 2000);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
